// File: rtl/y86_pkg.sv
// Shared Y86-64 decode definitions: instruction codes, register index type and
// the special register indices used by source selection.
package y86_pkg;

   typedef logic [3:0] reg_idx_t;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam reg_idx_t REG_NONE        = 4'hF;
   localparam reg_idx_t RSP_IDX_DEFAULT = 4'h4;

endpackage

// File: rtl/y86_regfile.sv
// Y86-64 register array with E/M write ports (M wins on collision) and two
// combinational read ports. Define Y86_RF_BYPASS_EN to forward same-cycle writes.
module y86_regfile
   import y86_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int NREGS = 15
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            we_e_i,
   input  reg_idx_t        dst_e_i,
   input  logic [XLEN-1:0] val_e_i,
   input  logic            we_m_i,
   input  reg_idx_t        dst_m_i,
   input  logic [XLEN-1:0] val_m_i,
   input  reg_idx_t        rd_idx_a_i,
   output logic [XLEN-1:0] rd_data_a_o,
   input  reg_idx_t        rd_idx_b_i,
   output logic [XLEN-1:0] rd_data_b_o
);

   logic [XLEN-1:0] regs_q [NREGS];
   logic [XLEN-1:0] regs_d [NREGS];
   logic [XLEN-1:0] arr_a_s;
   logic [XLEN-1:0] arr_b_s;

   function automatic logic idx_ok(input reg_idx_t idx);
      return (idx != REG_NONE) && (int'(idx) < NREGS);
   endfunction

`ifdef Y86_RF_BYPASS_EN
   function automatic logic [XLEN-1:0] fwd(input reg_idx_t idx, input logic [XLEN-1:0] base,
                                           input logic we_e, input reg_idx_t dst_e,
                                           input logic [XLEN-1:0] val_e, input logic we_m,
                                           input reg_idx_t dst_m, input logic [XLEN-1:0] val_m);
      return !idx_ok(idx)               ? base  :
             (we_m && (dst_m == idx))   ? val_m :
             (we_e && (dst_e == idx))   ? val_e : base;
   endfunction
`endif

   // Next array contents; the M port is checked first so it wins a collision.
   always_comb begin
      for (int i = 0; i < NREGS; i++) begin
         regs_d[i] = (we_m_i && idx_ok(dst_m_i) && (dst_m_i == 4'(i))) ? val_m_i :
                     (we_e_i && idx_ok(dst_e_i) && (dst_e_i == 4'(i))) ? val_e_i :
                     regs_q[i];
      end
   end

   // Array state; reset clears every register and drops writes in that cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Array read; out-of-range and "no register" indices return zero.
   always_comb begin
      arr_a_s = '0;
      arr_b_s = '0;
      for (int i = 0; i < NREGS; i++) begin
         arr_a_s = (idx_ok(rd_idx_a_i) && (rd_idx_a_i == 4'(i))) ? regs_q[i] : arr_a_s;
         arr_b_s = (idx_ok(rd_idx_b_i) && (rd_idx_b_i == 4'(i))) ? regs_q[i] : arr_b_s;
      end
   end

`ifdef Y86_RF_BYPASS_EN
   assign rd_data_a_o = fwd(rd_idx_a_i, arr_a_s, we_e_i, dst_e_i, val_e_i, we_m_i, dst_m_i, val_m_i);
   assign rd_data_b_o = fwd(rd_idx_b_i, arr_b_s, we_e_i, dst_e_i, val_e_i, we_m_i, dst_m_i, val_m_i);
`else
   assign rd_data_a_o = arr_a_s;
   assign rd_data_b_o = arr_b_s;
`endif

endmodule

// File: rtl/y86_regfile_decode.sv
// Y86-64 decode/writeback stage: source select, register file and a registered
// valid/ready output slot. Y86_RF_BYPASS_EN enables same-cycle write forwarding.
module y86_regfile_decode
   import y86_pkg::*;
#(
   parameter int       XLEN    = 64,
   parameter int       NREGS   = 15,
   parameter reg_idx_t RSP_IDX = RSP_IDX_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      icode,
   input  logic [3:0]      rA,
   input  logic [3:0]      rB,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [3:0]      icode_q,
   output logic [3:0]      srcA,
   output logic [3:0]      srcB,
   output logic [XLEN-1:0] valA,
   output logic [XLEN-1:0] valB,
   input  logic            wE_en,
   input  logic [3:0]      dstE,
   input  logic [XLEN-1:0] valE,
   input  logic            wM_en,
   input  logic [3:0]      dstM,
   input  logic [XLEN-1:0] valM
);

   reg_idx_t        sel_a_s;
   reg_idx_t        sel_b_s;
   logic [XLEN-1:0] rd_a_s;
   logic [XLEN-1:0] rd_b_s;
   logic            accept_s;

   logic            out_valid_q, out_valid_d;
   logic [3:0]      icode_hold_q, icode_hold_d;
   reg_idx_t        src_a_q, src_a_d;
   reg_idx_t        src_b_q, src_b_d;
   logic [XLEN-1:0] val_a_q, val_a_d;
   logic [XLEN-1:0] val_b_q, val_b_d;

   // Source A selection from the instruction code.
   always_comb begin
      sel_a_s = REG_NONE;
      case (icode)
         I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: sel_a_s = rA;
         I_RET, I_POPQ:                      sel_a_s = RSP_IDX;
         default:                            sel_a_s = REG_NONE;
      endcase
   end

   // Source B selection from the instruction code.
   always_comb begin
      sel_b_s = REG_NONE;
      case (icode)
         I_RMMOVQ, I_MRMOVQ, I_OPQ:         sel_b_s = rB;
         I_CALL, I_RET, I_PUSHQ, I_POPQ:    sel_b_s = RSP_IDX;
         default:                           sel_b_s = REG_NONE;
      endcase
   end

   y86_regfile #(
      .XLEN  (XLEN),
      .NREGS (NREGS)
   ) u_regfile (
      .clk_i       (clk),
      .rst_i       (rst),
      .we_e_i      (wE_en),
      .dst_e_i     (dstE),
      .val_e_i     (valE),
      .we_m_i      (wM_en),
      .dst_m_i     (dstM),
      .val_m_i     (valM),
      .rd_idx_a_i  (sel_a_s),
      .rd_data_a_o (rd_a_s),
      .rd_idx_b_i  (sel_b_s),
      .rd_data_b_o (rd_b_s)
   );

   // The slot is free when empty or being drained; never depends on in_valid.
   assign in_ready = !out_valid_q || out_ready;
   assign accept_s = in_valid && in_ready;

   // Output slot next state: capture on accept, drain on consume, else hold.
   always_comb begin
      out_valid_d  = out_valid_q;
      icode_hold_d = icode_hold_q;
      src_a_d      = src_a_q;
      src_b_d      = src_b_q;
      val_a_d      = val_a_q;
      val_b_d      = val_b_q;
      if (accept_s) begin
         out_valid_d  = 1'b1;
         icode_hold_d = icode;
         src_a_d      = sel_a_s;
         src_b_d      = sel_b_s;
         val_a_d      = rd_a_s;
         val_b_d      = rd_b_s;
      end else if (out_valid_q && out_ready) begin
         out_valid_d  = 1'b0;
      end else begin
         out_valid_d  = out_valid_q;
      end
   end

   // Output slot registers; reset discards any held result.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         icode_hold_q <= I_NOP;
         src_a_q      <= REG_NONE;
         src_b_q      <= REG_NONE;
         val_a_q      <= '0;
         val_b_q      <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         icode_hold_q <= icode_hold_d;
         src_a_q      <= src_a_d;
         src_b_q      <= src_b_d;
         val_a_q      <= val_a_d;
         val_b_q      <= val_b_d;
      end
   end

   assign out_valid = out_valid_q;
   assign icode_q   = icode_hold_q;
   assign srcA      = src_a_q;
   assign srcB      = src_b_q;
   assign valA      = val_a_q;
   assign valB      = val_b_q;

endmodule

// File: tb/tb_y86_regfile_decode.sv
// Self-checking bench for y86_regfile_decode: directed test-plan scenarios and
// randomized traffic, both checked every cycle against a behavioural model.
module tb_y86_regfile_decode;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [3:0]  icode, rA, rB;
   logic        out_valid, out_ready;
   logic [3:0]  icode_q, srcA, srcB;
   logic [63:0] valA, valB;
   logic        wE_en, wM_en;
   logic [3:0]  dstE, dstM;
   logic [63:0] valE, valM;

   int total = 0;
   int bad   = 0;

   // model state
   logic [63:0] m_regs [15];
   logic        m_ov;
   logic [3:0]  m_icode, m_srcA, m_srcB;
   logic [63:0] m_valA, m_valB;

   y86_regfile_decode dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .icode(icode), .rA(rA), .rB(rB), .out_valid(out_valid), .out_ready(out_ready),
      .icode_q(icode_q), .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
      .wE_en(wE_en), .dstE(dstE), .valE(valE), .wM_en(wM_en), .dstM(dstM), .valM(valM)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] m_src_a(input logic [3:0] ic, input logic [3:0] ra);
      if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
      if (ic inside {4'h9, 4'hB}) return 4'h4;
      return 4'hF;
   endfunction

   function automatic logic [3:0] m_src_b(input logic [3:0] ic, input logic [3:0] rb);
      if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
      if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
      return 4'hF;
   endfunction

   function automatic logic [63:0] m_read(input logic [3:0] idx);
      logic [63:0] v;
      if (idx >= 4'd15) return 64'd0;
      v = m_regs[idx];
`ifdef Y86_RF_BYPASS_EN
      if (wE_en && dstE == idx) v = valE;
      if (wM_en && dstM == idx) v = valM;
`endif
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   // advance the model across one rising edge using the inputs now applied
   task automatic model_edge();
      logic acc;
      if (rst) begin
         for (int i = 0; i < 15; i++) m_regs[i] = 64'd0;
         m_ov = 1'b0; m_icode = 4'h1; m_srcA = 4'hF; m_srcB = 4'hF;
         m_valA = 64'd0; m_valB = 64'd0;
      end else begin
         acc = in_valid && (!m_ov || out_ready);
         if (acc) begin
            m_srcA  = m_src_a(icode, rA);
            m_srcB  = m_src_b(icode, rB);
            m_valA  = m_read(m_srcA);
            m_valB  = m_read(m_srcB);
            m_icode = icode;
            m_ov    = 1'b1;
         end else if (m_ov && out_ready) begin
            m_ov = 1'b0;
         end
         if (wE_en && dstE != 4'hF) m_regs[dstE] = valE;
         if (wM_en && dstM != 4'hF) m_regs[dstM] = valM;
      end
   endtask

   task automatic compare();
      chk("out_valid", {63'd0, out_valid}, {63'd0, m_ov});
      chk("in_ready", {63'd0, in_ready}, {63'd0, (!m_ov || out_ready)});
      chk("icode_q", {60'd0, icode_q}, {60'd0, m_icode});
      chk("srcA", {60'd0, srcA}, {60'd0, m_srcA});
      chk("srcB", {60'd0, srcB}, {60'd0, m_srcB});
      chk("valA", valA, m_valA);
      chk("valB", valB, m_valB);
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      @(negedge clk);
      compare();
   endtask

   task automatic idle();
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      icode = 4'h1; rA = 4'hF; rB = 4'hF;
      wE_en = 1'b0; dstE = 4'hF; valE = 64'd0;
      wM_en = 1'b0; dstM = 4'hF; valM = 64'd0;
   endtask

   task automatic wr2(input logic [3:0] de, input logic [63:0] ve,
                      input logic [3:0] dm, input logic [63:0] vm);
      wE_en = 1'b1; dstE = de; valE = ve;
      wM_en = 1'b1; dstM = dm; valM = vm;
   endtask

   task automatic req(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b);
      in_valid = 1'b1; icode = ic; rA = a; rB = b;
   endtask

   initial begin
      idle();
      // reset with a write that must be dropped
      rst = 1'b1; wE_en = 1'b1; dstE = 4'd2; valE = 64'd5;
      step();
      step();
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_srcA", {60'd0, srcA}, 64'hF);
      chk("rst_srcB", {60'd0, srcB}, 64'hF);
      chk("rst_icode", {60'd0, icode_q}, 64'h1);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      idle(); req(4'h2, 4'd2, 4'hF);
      step();
      chk("rst_r2_zero", valA, 64'd0);

      // cmovxx
      idle(); wr2(4'd0, 64'h69, 4'd2, 64'h3E);
      step();
      idle(); req(4'h2, 4'd0, 4'd2);
      step();
      chk("cmov_srcA", {60'd0, srcA}, 64'd0);
      chk("cmov_valA", valA, 64'h69);
      chk("cmov_srcB", {60'd0, srcB}, 64'hF);
      chk("cmov_valB", valB, 64'd0);

      // stack ops
      idle(); wr2(4'd4, 64'h2B, 4'd9, 64'hE6);
      step();
      idle(); req(4'h9, 4'hF, 4'hF);
      step();
      chk("ret_valA", valA, 64'h2B);
      chk("ret_valB", valB, 64'h2B);
      req(4'hA, 4'd9, 4'hF);
      step();
      chk("push_valA", valA, 64'hE6);
      chk("push_valB", valB, 64'h2B);
      req(4'h8, 4'hF, 4'hF);
      step();
      chk("call_srcA", {60'd0, srcA}, 64'hF);
      chk("call_valB", valB, 64'h2B);

      // stall with writeback continuing underneath
      idle(); wE_en = 1'b1; dstE = 4'd6; valE = 64'h57;
      step();
      idle(); req(4'h6, 4'd6, 4'd9);
      step();
      chk("opq_valA", valA, 64'h57);
      out_ready = 1'b0; req(4'h6, 4'd6, 4'd9);
      wE_en = 1'b1; dstE = 4'd6; valE = 64'h99;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("stall_valA", valA, 64'h57);
         chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
      end
      idle(); req(4'h6, 4'd6, 4'd9);
      step();
      chk("post_stall_valA", valA, 64'h99);

      // dual write to the same register
      idle(); wr2(4'd4, 64'h10, 4'd4, 64'h20);
      step();
      idle(); req(4'h9, 4'hF, 4'hF);
      step();
      chk("dual_write_r4", valB, 64'h20);

      // same-cycle read/write
      idle(); wE_en = 1'b1; dstE = 4'd6; valE = 64'h57;
      step();
      idle(); req(4'h5, 4'hF, 4'd6); wE_en = 1'b1; dstE = 4'd6; valE = 64'h77;
      step();
`ifdef Y86_RF_BYPASS_EN
      chk("rw_same_cycle", valB, 64'h77);
`else
      chk("rw_same_cycle", valB, 64'h57);
`endif
      idle(); req(4'h5, 4'hF, 4'd6);
      step();
      chk("rw_next_cycle", valB, 64'h77);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rst       = ($urandom_range(63) == 0);
         in_valid  = $urandom_range(1);
         out_ready = ($urandom_range(3) != 0);
         icode     = 4'($urandom_range(15));
         rA        = 4'($urandom_range(15));
         rB        = 4'($urandom_range(15));
         wE_en     = $urandom_range(1);
         dstE      = 4'($urandom_range(15));
         valE      = {$urandom, $urandom};
         wM_en     = $urandom_range(1);
         dstM      = ($urandom_range(3) == 0) ? dstE : 4'($urandom_range(15));
         valM      = {$urandom, $urandom};
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
